jstk_poll_sequencer: RTL

//  Transaction controller for the PmodJSTK SPI joystick. Periodically opens a CS frame and sequences five
//  SPI byte transfers with the required CS-setup and inter-byte gaps. Sends the LED command and captures the
//  X/Y/button report. Its registered outputs feed the paddle logic and the 4-digit hex display.

---
 rtl/jstk_poll_sequencer_pkg.sv | 25 ++
 rtl/jstk_poll_sequencer_spi_byte_master.sv | 104 ++++++++++
 rtl/jstk_poll_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/jstk_poll_sequencer_pkg.sv
// Shared definitions for the PmodJSTK poll sequencer.
//   state_e          : top-level frame FSM states
//   JSTK_CMD_PREFIX  : upper six bits of the LED command byte
//   NUM_BYTES        : SPI bytes per joystick frame
//   tx_byte_f        : byte to transmit for a given byte index and latched LEDs
package jstk_poll_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_FINISH,
    ST_WAIT
  } state_e;

  localparam logic [5:0]  JSTK_CMD_PREFIX = 6'b100000;
  localparam int unsigned NUM_BYTES       = 5;

  // Byte 0 carries the LED command; the remaining bytes are dummies.
  function automatic logic [7:0] tx_byte_f(input logic [2:0] idx, input logic [1:0] ld);
    return (idx == 3'd0) ? {JSTK_CMD_PREFIX, ld} : 8'h00;
  endfunction

endpackage

// File: rtl/jstk_poll_sequencer_spi_byte_master.sv
// spi_byte_master: one mode-0 SPI byte, MSB first.
//   clk50M, rst      : clock, synchronous active-high reset
//   start            : begin a byte (accepted only when idle); first sck rise is on the accept edge
//   load             : while idle, park mosi on tx_byte[7] so it is valid before the first rise
//   tx_byte          : byte to send (sampled on start)
//   rx_byte          : shift register holding the received bits
//   done             : 1-cycle pulse in the last cycle of the byte (end of final sck-low half)
//   sck, mosi, miso  : SPI pins
// A byte is 16 half-periods of SCK_HALF cycles: rise, fall, ..., final fall, final low half.
module spi_byte_master #(
  parameter int SCK_HALF = 25
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       start,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic          active_q, active_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [3:0]    hidx_q, hidx_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic [6:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          half_end;

  always_comb begin
    active_d = active_q;
    hcnt_d   = hcnt_q;
    hidx_d   = hidx_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    half_end = active_q && (hcnt_q == HW'(SCK_HALF - 1));
    done     = half_end && (hidx_q == 4'd15);
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        hcnt_d   = '0;
        hidx_d   = '0;
        sck_d    = 1'b1;
        mosi_d   = tx_byte[7];
        tx_d     = tx_byte[6:0];
        rx_d     = {rx_q[6:0], miso};
      end else if (load) begin
        mosi_d = tx_byte[7];
      end
    end else if (half_end) begin
      hcnt_d = '0;
      if (hidx_q == 4'd15) begin
        active_d = 1'b0;
      end else begin
        hidx_d = hidx_q + 4'd1;
        if (hidx_q[0]) begin
          // low half ends: rise and sample
          sck_d = 1'b1;
          rx_d  = {rx_q[6:0], miso};
        end else begin
          // high half ends: fall and present the next bit (0 after the last)
          sck_d  = 1'b0;
          mosi_d = tx_q[6];
          tx_d   = {tx_q[5:0], 1'b0};
        end
      end
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      active_q <= 1'b0;
      hcnt_q   <= '0;
      hidx_q   <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      hcnt_q   <= hcnt_d;
      hidx_q   <= hidx_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign rx_byte = rx_q;

endmodule

// File: rtl/jstk_poll_sequencer.sv
// jstk_poll_sequencer: periodic PmodJSTK frame controller.
//   clk50M, rst        : clock, synchronous active-high reset
//   enable             : keep polling; dropping it lets the current frame finish
//   LD1, LD2           : LED commands, latched at frame start
//   x, y, btn          : last complete report (updated atomically)
//   sample_valid       : 1-cycle pulse with each report update
//   busy               : frame in progress (SETUP/SHIFT/GAP/FINISH)
//   cs, sck, mosi, miso: SPI pins
module jstk_poll_sequencer
  import jstk_poll_sequencer_pkg::*;
#(
  parameter int SCK_HALF     = 25,
  parameter int CS_SETUP_CYC = 750,
  parameter int BYTE_GAP_CYC = 500,
  parameter int POLL_CYC     = 500000
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       enable,
  input  logic       LD1,
  input  logic       LD2,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [1:0] btn,
  output logic       sample_valid,
  output logic       busy,
  output logic       cs,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam int CMAX = (CS_SETUP_CYC > BYTE_GAP_CYC)
                      ? ((CS_SETUP_CYC > POLL_CYC) ? CS_SETUP_CYC : POLL_CYC)
                      : ((BYTE_GAP_CYC > POLL_CYC) ? BYTE_GAP_CYC : POLL_CYC);
  localparam int CW = $clog2(CMAX + 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [1:0]  ld_q, ld_d;
  // shadow copies of the report fields, assembled byte by byte
  logic [9:0]  xs_q, xs_d, ys_q, ys_d;
  logic [1:0]  bs_q, bs_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  btn_q, btn_d;
  logic        sv_q, sv_d, busy_q, busy_d, cs_q, cs_d;

  logic        start, load, done;
  logic [7:0]  tx_byte, rx_byte;

  spi_byte_master #(.SCK_HALF(SCK_HALF)) u_spi (
    .clk50M (clk50M),
    .rst    (rst),
    .start  (start),
    .load   (load),
    .tx_byte(tx_byte),
    .rx_byte(rx_byte),
    .done   (done),
    .sck    (sck),
    .mosi   (mosi),
    .miso   (miso)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    ld_d       = ld_q;
    xs_d       = xs_q;
    ys_d       = ys_q;
    bs_d       = bs_q;
    x_d        = x_q;
    y_d        = y_q;
    btn_d      = btn_q;
    sv_d       = 1'b0;
    start      = 1'b0;
    case (state_q)
      ST_IDLE: if (enable) begin
        state_d    = ST_SETUP;
        ld_d       = {LD2, LD1};
        byte_idx_d = '0;
        cnt_d      = '0;
      end
      ST_SETUP: if (cnt_q == CW'(CS_SETUP_CYC - 1)) begin
        start   = 1'b1;
        state_d = ST_SHIFT;
      end else cnt_d = cnt_q + CW'(1);
      ST_SHIFT: if (done) begin
        case (byte_idx_q)
          3'd0:    xs_d[7:0] = rx_byte;
          3'd1:    xs_d[9:8] = rx_byte[1:0];
          3'd2:    ys_d[7:0] = rx_byte;
          3'd3:    ys_d[9:8] = rx_byte[1:0];
          default: bs_d      = {rx_byte[2], rx_byte[1]};
        endcase
        cnt_d = '0;
        if (byte_idx_q == 3'(NUM_BYTES - 1)) state_d = ST_FINISH;
        else begin
          state_d    = ST_GAP;
          byte_idx_d = byte_idx_q + 3'd1;
        end
      end
      ST_GAP: if (cnt_q == CW'(BYTE_GAP_CYC - 1)) begin
        start   = 1'b1;
        state_d = ST_SHIFT;
      end else cnt_d = cnt_q + CW'(1);
      ST_FINISH: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
        x_d     = xs_q;
        y_d     = ys_q;
        btn_d   = bs_q;
        sv_d    = 1'b1;
      end
      ST_WAIT: if (cnt_q == CW'(POLL_CYC - 1)) begin
        cnt_d = '0;
        if (enable) begin
          state_d    = ST_SETUP;
          ld_d       = {LD2, LD1};
          byte_idx_d = '0;
        end else state_d = ST_IDLE;
      end else cnt_d = cnt_q + CW'(1);
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
              (state_d == ST_GAP)   || (state_d == ST_FINISH);
    cs_d    = ~busy_d;
    // mosi is parked on the next byte's MSB from the edge SETUP/GAP is entered
    load    = (state_d == ST_SETUP) || (state_d == ST_GAP);
    tx_byte = tx_byte_f(byte_idx_d, ld_d);
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      ld_q       <= '0;
      xs_q       <= '0;
      ys_q       <= '0;
      bs_q       <= '0;
      sv_q       <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b1;
      // A reset that lands mid-frame keeps the last complete report;
      // a reset while not busy (including any reset held >1 cycle) clears it.
      if (!busy_q) begin
        x_q   <= '0;
        y_q   <= '0;
        btn_q <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      ld_q       <= ld_d;
      xs_q       <= xs_d;
      ys_q       <= ys_d;
      bs_q       <= bs_d;
      x_q        <= x_d;
      y_q        <= y_d;
      btn_q      <= btn_d;
      sv_q       <= sv_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign btn          = btn_q;
  assign sample_valid = sv_q;
  assign busy         = busy_q;
  assign cs           = cs_q;

endmodule
